game_over_ctrl: RTL and testbench
=================================

Name: game_over_ctrl

Overview:
Parametrised game-end controller. Replaces the single-bit game-over latch.
Accepts N_SRC game-over request lines (one per player/hazard), confirms each request over a programmable number of consecutive cycles, and runs an optional freeze ("ending") phase before asserting over. It latches which source(s) caused the end and holds that until a restart request.
Sits between the collision/game-logic blocks and the draw and menu blocks.

Parameters:
N_SRC, 2, number of game-over request sources; must be at least 1.
CONFIRM_CYCLES, 1, number of consecutive cycles with gameover != 0 required to accept an end; must be at least 1.
ENDING_CYCLES, 0, length in cycles of the freeze phase before over asserts; 0 skips the phase.
SCORE_W, 8, width of each per-source tally counter; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
gameover  in  N_SRC  per-source game-over request; level-sensitive
reset  in  1  restart request from menu/keyboard; level-sensitive
freeze  out  1  high in ENDING and OVER; game logic halts motion
over  out  1  high only in OVER
cause  out  N_SRC  gameover vector latched at the confirming edge; 0 outside ENDING/OVER
cause_id  out  $clog2(N_SRC) or 1 if N_SRC==1  index of the lowest set bit of cause; 0 when cause==0
state_o  out  2  current state encoding, for debug/overlay
score  out  N_SRC*SCORE_W  per-source tally, packed with source i at [i*SCORE_W +: SCORE_W]; present only with GAME_OVER_SCORE_EN

Behaviour:
- All outputs are registered.
- Reset values: state RUN, freeze 0, over 0, cause 0, cause_id 0, confirm and ending counters 0, and score 0 when the feature is compiled in.
- State encoding: RUN=0, CONFIRM=1, ENDING=2, OVER=3.
- reset has priority in every state. When reset=1 at an edge:
  - next state is RUN
  - cause and cause_id clear
  - both counters clear
  - score is not affected
- RUN, gameover != 0:
  - If CONFIRM_CYCLES==1, this edge is the confirming edge.
  - Otherwise go to CONFIRM with confirm count = 1.
- CONFIRM:
  - gameover == 0 returns to RUN and clears the count.
  - Otherwise the count increments. The edge that samples the CONFIRM_CYCLES-th consecutive nonzero cycle is the confirming edge.
  - The set of active sources may change during CONFIRM; only "any nonzero" matters.
- Confirming edge:
  - Latch cause = gameover sampled at that edge; latch cause_id from it.
  - Next state is ENDING if ENDING_CYCLES > 0, otherwise OVER.
- ENDING:
  - freeze=1, over=0.
  - Counts ENDING_CYCLES cycles, then goes to OVER. over therefore rises exactly ENDING_CYCLES cycles after freeze rises.
- OVER:
  - freeze=1, over=1.
  - gameover is ignored; the state holds until reset=1.
- Latency with default parameters: gameover sampled high at edge k gives over=1 after edge k. This is backward compatible with the single-bit latch.
- Simultaneous reset and gameover: reset wins and the block stays in RUN. An end needs a fresh confirmation after reset drops.
- Counter widths: $clog2(max+1) of the respective parameter. Counters never wrap because they are bounded by their state.

Optional Feature:
- Macro: GAME_OVER_SCORE_EN.
- When defined:
  - The score port exists.
  - On each confirming edge, every source with its bit set in the latched cause increments its counter by 1.
  - Counters saturate at 2^SCORE_W-1.
  - Only rst clears score.
- When undefined: no score port and no counters. All other behaviour is identical.

Decomposition:
- Shared package game_over_pkg holds:
  - the state enum (RUN, CONFIRM, ENDING, OVER) as a 2-bit typedef
  - the function computing the lowest set index
- One natural sub-module: go_cycle_counter, a parametrised up-counter with clear, enable and terminal-count flag. It is instantiated twice, for confirm and ending.

Test Plan:
1. Defaults (N_SRC=2, CONFIRM=1, ENDING=0): gameover=2'b10 for 1 cycle -> next cycle over=1, freeze=1, cause=2'b10, cause_id=1. over holds with gameover=0 until reset=1; one cycle later over=0, cause=0.
2. CONFIRM_CYCLES=3: gameover pulse 2 cycles, gap, then 3 cycles -> no over after the 2-cycle pulse. Reaches ENDING/OVER only after the 3rd consecutive cycle. state_o goes 0,1,1,0 during the 2-cycle pulse and gap.
3. ENDING_CYCLES=4: confirm at edge k -> freeze=1 after edge k, state_o=2 for 4 cycles, over=1 after edge k+4.
4. gameover=2'b11 and reset=1 at the same edge -> state stays RUN and over stays 0. Next cycle, reset=0 with gameover=2'b11 -> over=1, cause=2'b11, cause_id=0.
5. reset=1 during ENDING (ENDING_CYCLES=4, 2nd cycle) -> RUN next cycle, freeze=0, cause=0, and over never asserts.
6. With GAME_OVER_SCORE_EN and SCORE_W=2: five games ended by source 0 -> score[0] reads 1,2,3,3,3 and score[1]=0. A following rst -> all scores 0.

Source files
------------

// File: rtl/game_over_pkg.sv
// game_over_pkg -- shared types and helpers for the game-end controller.
//
// Contents:
//   go_state_e      2-bit FSM state; the encoding is visible on state_o
//                   (RUN=0, CONFIRM=1, ENDING=2, OVER=3)
//   MAX_SRC         widest request vector lowest_set_idx() accepts
//   lowest_set_idx  index of the lowest set bit, 0 when no bit is set
package game_over_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_ENDING  = 2'd2,
        ST_OVER    = 2'd3
    } go_state_e;

    localparam int unsigned MAX_SRC = 32;

    // Callers zero-extend their vector to MAX_SRC bits and truncate the result.
    function automatic logic [31:0] lowest_set_idx(input logic [MAX_SRC-1:0] v);
        logic        found;
        logic [31:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (v[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/go_cycle_counter.sv
// go_cycle_counter -- up-counter with synchronous clear, enable and a
// terminal-count flag.
//
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clr_i  in  clear to 0 (wins over en_i)
//   en_i   in  count up by one
//   tc_o   out high while the count equals MAX-1, i.e. the next enabled
//              cycle is the MAX-th one; tied high when MAX is 0
//
// The owner only enables the counter while its state bounds the count, so
// no wrap protection is built in.
module go_cycle_counter #(
    parameter int unsigned MAX = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] TC_VAL = W'((MAX == 0) ? 0 : MAX - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (MAX == 0) ? 1'b1 : (count_q == TC_VAL);

endmodule

// File: rtl/game_over_ctrl.sv
// game_over_ctrl -- parametrised game-end controller.
//
// A game-over request (any bit of gameover) must stay nonzero for
// CONFIRM_CYCLES consecutive cycles. On the confirming edge the request
// vector is latched as cause, then the block freezes for ENDING_CYCLES
// cycles (ENDING) before asserting over (OVER). OVER holds until the
// restart request 'reset'. 'reset' wins over everything, in every state.
// All outputs are registered.
//
// Optional feature: define GAME_OVER_SCORE_EN to add the score port and one
// saturating SCORE_W-bit tally per source, bumped on every confirming edge
// for each source set in the latched cause; only rst clears the tallies.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   gameover  in   [N_SRC]   per-source game-over request, level
//   reset     in   restart request from menu/keyboard, level
//   freeze    out  high in ENDING and OVER
//   over      out  high only in OVER
//   cause     out  [N_SRC]   gameover latched at the confirming edge
//   cause_id  out  [CID_W]   lowest set index of cause (0 if none)
//   state_o   out  [2]       current state encoding
//   score     out  [N_SRC*SCORE_W]  per-source tally (GAME_OVER_SCORE_EN)
module game_over_ctrl
    import game_over_pkg::*;
#(
    parameter int unsigned N_SRC          = 2,
    parameter int unsigned CONFIRM_CYCLES = 1,
    parameter int unsigned ENDING_CYCLES  = 0,
    parameter int unsigned SCORE_W        = 8,
    localparam int unsigned CID_W         = (N_SRC <= 1) ? 1 : $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] gameover,
    input  logic             reset,
    output logic             freeze,
    output logic             over,
    output logic [N_SRC-1:0] cause,
    output logic [CID_W-1:0] cause_id,
    output logic [1:0]       state_o
`ifdef GAME_OVER_SCORE_EN
    ,
    output logic [N_SRC*SCORE_W-1:0] score
`endif
);

    if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_n_src
        $error("game_over_ctrl: N_SRC out of range");
    end
    if (CONFIRM_CYCLES < 1) begin : g_bad_confirm
        $error("game_over_ctrl: CONFIRM_CYCLES must be at least 1");
    end
    if (SCORE_W < 1) begin : g_bad_score_w
        $error("game_over_ctrl: SCORE_W must be at least 1");
    end

    go_state_e        state_q, state_d;
    logic             freeze_q, over_q;
    logic [N_SRC-1:0] cause_q, cause_d;
    logic [CID_W-1:0] cid_q, cid_d;

    logic any_go;
    logic confirm_hit;
    logic conf_clr, conf_en, conf_tc;
    logic end_clr, end_en, end_tc;

    assign any_go = |gameover;

    go_cycle_counter #(.MAX(CONFIRM_CYCLES)) u_confirm_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (conf_clr),
        .en_i  (conf_en),
        .tc_o  (conf_tc)
    );

    go_cycle_counter #(.MAX(ENDING_CYCLES)) u_ending_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (end_clr),
        .en_i  (end_en),
        .tc_o  (end_tc)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cid_d       = cid_q;
        confirm_hit = 1'b0;
        conf_clr    = 1'b0;
        conf_en     = 1'b0;
        end_clr     = 1'b0;
        end_en      = 1'b0;

        if (reset) begin
            state_d  = ST_RUN;
            cause_d  = '0;
            cid_d    = '0;
            conf_clr = 1'b1;
            end_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (any_go) begin
                        if (CONFIRM_CYCLES == 1) begin
                            confirm_hit = 1'b1;
                        end else begin
                            // Entering CONFIRM already accounts for this cycle.
                            state_d = ST_CONFIRM;
                            conf_en = 1'b1;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!any_go) begin
                        state_d  = ST_RUN;
                        conf_clr = 1'b1;
                    end else if (conf_tc) begin
                        confirm_hit = 1'b1;
                        conf_clr    = 1'b1;
                    end else begin
                        conf_en = 1'b1;
                    end
                end
                ST_ENDING: begin
                    if (end_tc) begin
                        state_d = ST_OVER;
                        end_clr = 1'b1;
                    end else begin
                        end_en = 1'b1;
                    end
                end
                ST_OVER: begin
                    // gameover ignored; only reset leaves OVER.
                end
            endcase

            if (confirm_hit) begin
                cause_d = gameover;
                cid_d   = CID_W'(lowest_set_idx(MAX_SRC'(gameover)));
                state_d = (ENDING_CYCLES > 0) ? ST_ENDING : ST_OVER;
            end
        end
    end

    // Flag outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            freeze_q <= 1'b0;
            over_q   <= 1'b0;
            cause_q  <= '0;
            cid_q    <= '0;
        end else begin
            state_q  <= state_d;
            freeze_q <= (state_d == ST_ENDING) || (state_d == ST_OVER);
            over_q   <= (state_d == ST_OVER);
            cause_q  <= cause_d;
            cid_q    <= cid_d;
        end
    end

    assign freeze   = freeze_q;
    assign over     = over_q;
    assign cause    = cause_q;
    assign cause_id = cid_q;
    assign state_o  = state_q;

`ifdef GAME_OVER_SCORE_EN
    logic [N_SRC*SCORE_W-1:0] score_q;

    // gameover at the confirming edge is exactly the cause being latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (confirm_hit) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (gameover[i] && (score_q[i*SCORE_W +: SCORE_W] != '1)) begin
                    score_q[i*SCORE_W +: SCORE_W] <= score_q[i*SCORE_W +: SCORE_W] + 1'b1;
                end
            end
        end
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_game_over_ctrl.sv
module tb_game_over_ctrl;

    typedef struct {
        logic [1:0] go;
        logic       rs;
        logic [1:0] st;
        logic       fr;
        logic       ov;
        logic [1:0] cause;
        logic       cid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // dut_a: default timing; dut_b: CONFIRM_CYCLES=3, ENDING_CYCLES=4
    logic [1:0] go_a = '0, go_b = '0;
    logic       rs_a = 1'b0, rs_b = 1'b0;
    logic       fr_a, ov_a, fr_b, ov_b;
    logic [1:0] cause_a, cause_b, st_a, st_b;
    logic       cid_a, cid_b;
`ifdef GAME_OVER_SCORE_EN
    logic [3:0] score_a, score_b;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    vec_t ta[10];
    vec_t tb[19];

    always #5 clk = ~clk;

    game_over_ctrl #(
        .N_SRC(2), .CONFIRM_CYCLES(1), .ENDING_CYCLES(0), .SCORE_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .gameover(go_a), .reset(rs_a),
        .freeze(fr_a), .over(ov_a), .cause(cause_a), .cause_id(cid_a),
        .state_o(st_a)
`ifdef GAME_OVER_SCORE_EN
        , .score(score_a)
`endif
    );

    game_over_ctrl #(
        .N_SRC(2), .CONFIRM_CYCLES(3), .ENDING_CYCLES(4), .SCORE_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .gameover(go_b), .reset(rs_b),
        .freeze(fr_b), .over(ov_b), .cause(cause_b), .cause_id(cid_b),
        .state_o(st_b)
`ifdef GAME_OVER_SCORE_EN
        , .score(score_b)
`endif
    );

    function automatic vec_t mk(input logic [1:0] go, input logic rs,
                                input logic [1:0] st, input logic fr,
                                input logic ov, input logic [1:0] cause,
                                input logic cid);
        vec_t v;
        v.go = go; v.rs = rs; v.st = st; v.fr = fr;
        v.ov = ov; v.cause = cause; v.cid = cid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector before the edge, compare the registered outputs after it.
    task automatic run_vec(input int which, input int idx, input vec_t v);
        string p;
        @(negedge clk);
        if (which == 0) begin go_a = v.go; rs_a = v.rs; end
        else            begin go_b = v.go; rs_b = v.rs; end
        @(posedge clk);
        #1;
        p = $sformatf("%s[%0d]", (which == 0) ? "A" : "B", idx);
        if (which == 0) begin
            chk({p, ".state"},  32'(st_a),    32'(v.st));
            chk({p, ".freeze"}, 32'(fr_a),    32'(v.fr));
            chk({p, ".over"},   32'(ov_a),    32'(v.ov));
            chk({p, ".cause"},  32'(cause_a), 32'(v.cause));
            chk({p, ".cid"},    32'(cid_a),   32'(v.cid));
        end else begin
            chk({p, ".state"},  32'(st_b),    32'(v.st));
            chk({p, ".freeze"}, 32'(fr_b),    32'(v.fr));
            chk({p, ".over"},   32'(ov_b),    32'(v.ov));
            chk({p, ".cause"},  32'(cause_b), 32'(v.cause));
            chk({p, ".cid"},    32'(cid_b),   32'(v.cid));
        end
    endtask

    initial begin
        //            go     rs    st  fr  ov  cause  cid
        ta[0] = mk(2'b00, 1'b0, 2'd0, 0, 0, 2'b00, 0);
        ta[1] = mk(2'b10, 1'b0, 2'd3, 1, 1, 2'b10, 1);  // one-cycle latency
        ta[2] = mk(2'b00, 1'b0, 2'd3, 1, 1, 2'b10, 1);  // OVER holds
        ta[3] = mk(2'b01, 1'b0, 2'd3, 1, 1, 2'b10, 1);  // gameover ignored
        ta[4] = mk(2'b00, 1'b1, 2'd0, 0, 0, 2'b00, 0);  // restart
        ta[5] = mk(2'b11, 1'b1, 2'd0, 0, 0, 2'b00, 0);  // reset beats gameover
        ta[6] = mk(2'b11, 1'b0, 2'd3, 1, 1, 2'b11, 0);
        ta[7] = mk(2'b00, 1'b1, 2'd0, 0, 0, 2'b00, 0);
        ta[8] = mk(2'b01, 1'b0, 2'd3, 1, 1, 2'b01, 0);
        ta[9] = mk(2'b00, 1'b1, 2'd0, 0, 0, 2'b00, 0);

        tb[0]  = mk(2'b00, 1'b0, 2'd0, 0, 0, 2'b00, 0);
        tb[1]  = mk(2'b01, 1'b0, 2'd1, 0, 0, 2'b00, 0);  // 2-cycle pulse
        tb[2]  = mk(2'b10, 1'b0, 2'd1, 0, 0, 2'b00, 0);
        tb[3]  = mk(2'b00, 1'b0, 2'd0, 0, 0, 2'b00, 0);  // gap drops it
        tb[4]  = mk(2'b01, 1'b0, 2'd1, 0, 0, 2'b00, 0);
        tb[5]  = mk(2'b01, 1'b0, 2'd1, 0, 0, 2'b00, 0);
        tb[6]  = mk(2'b11, 1'b0, 2'd2, 1, 0, 2'b11, 0);  // confirm, edge k
        tb[7]  = mk(2'b00, 1'b0, 2'd2, 1, 0, 2'b11, 0);
        tb[8]  = mk(2'b00, 1'b0, 2'd2, 1, 0, 2'b11, 0);
        tb[9]  = mk(2'b00, 1'b0, 2'd2, 1, 0, 2'b11, 0);
        tb[10] = mk(2'b00, 1'b0, 2'd3, 1, 1, 2'b11, 0);  // edge k+4
        tb[11] = mk(2'b00, 1'b1, 2'd0, 0, 0, 2'b00, 0);
        tb[12] = mk(2'b10, 1'b0, 2'd1, 0, 0, 2'b00, 0);
        tb[13] = mk(2'b10, 1'b0, 2'd1, 0, 0, 2'b00, 0);
        tb[14] = mk(2'b10, 1'b0, 2'd2, 1, 0, 2'b10, 1);
        tb[15] = mk(2'b00, 1'b0, 2'd2, 1, 0, 2'b10, 1);
        tb[16] = mk(2'b00, 1'b1, 2'd0, 0, 0, 2'b00, 0);  // reset in ENDING
        tb[17] = mk(2'b00, 1'b0, 2'd0, 0, 0, 2'b00, 0);
        tb[18] = mk(2'b00, 1'b0, 2'd0, 0, 0, 2'b00, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.A.state",  32'(st_a),    32'd0);
        chk("rst.A.freeze", 32'(fr_a),    32'd0);
        chk("rst.A.over",   32'(ov_a),    32'd0);
        chk("rst.A.cause",  32'(cause_a), 32'd0);
        chk("rst.B.state",  32'(st_b),    32'd0);
        chk("rst.B.over",   32'(ov_b),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(0, i, ta[i]);
        @(negedge clk);
        go_a = '0; rs_a = 1'b0;
        for (int i = 0; i < 19; i++) run_vec(1, i, tb[i]);
        @(negedge clk);
        go_b = '0; rs_b = 1'b0;

`ifdef GAME_OVER_SCORE_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("score.clr0", 32'(score_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 1; g <= 5; g++) begin
            @(negedge clk);
            go_a = 2'b01;
            @(posedge clk);
            #1;
            chk($sformatf("score.g%0d.over", g), 32'(ov_a), 32'd1);
            chk($sformatf("score.g%0d.s0", g), 32'(score_a[1:0]), (g > 3) ? 32'd3 : 32'(g));
            chk($sformatf("score.g%0d.s1", g), 32'(score_a[3:2]), 32'd0);
            @(negedge clk);
            go_a = 2'b00; rs_a = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("score.g%0d.keep", g), 32'(score_a[1:0]), (g > 3) ? 32'd3 : 32'(g));
            @(negedge clk);
            rs_a = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("score.clr1", 32'(score_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
